vga_pattern_sched: RTL

Frame-synchronous scheduler that selects which test pattern the VGA pixel generator draws. It detects frame boundaries from the vsync output of the sync generator and advances the pattern index in one of two ways: automatically every N frames, or manually on a step request. It also accepts host configuration through a valid/ready handshake. All changes land only at a frame boundary, inside vertical blanking, so no frame ever shows a torn pattern.

---
 rtl/vga_pkg.sv | 21 ++
 rtl/vga_frame_edge.sv | 32 +++
 rtl/vga_pattern_sched.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-pattern blocks.
//   sched_state_t : scheduler FSM states (IDLE, AUTO, MANUAL)
//   PAT_*         : pattern index constants shared with the pixel generator
package vga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_AUTO   = 2'd1,
    ST_MANUAL = 2'd2
  } sched_state_t;

  localparam int unsigned PAT_COLORBARS   = 0;
  localparam int unsigned PAT_GRAYRAMP    = 1;
  localparam int unsigned PAT_CHECKER     = 2;
  localparam int unsigned PAT_GRID        = 3;
  localparam int unsigned PAT_SOLID_RED   = 4;
  localparam int unsigned PAT_SOLID_GREEN = 5;
  localparam int unsigned PAT_SOLID_BLUE  = 6;
  localparam int unsigned PAT_BORDER      = 7;

endpackage

// File: rtl/vga_frame_edge.sv
// Frame boundary detector: normalises sync polarity and flags the assert edge.
//   clk, rst    : clock, asynchronous active-low reset
//   sync_in     : raw vertical sync
//   frame_edge  : combinational assert-edge flag (cycle before frame_start)
//   frame_start : registered one-cycle pulse per assert edge
module vga_frame_edge #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  output logic frame_edge,
  output logic frame_start
);

  logic sync_n;
  logic sync_q;

  assign sync_n     = sync_in ^ ACTIVE_LOW;
  assign frame_edge = sync_n & ~sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      sync_q      <= sync_n;
      frame_start <= frame_edge;
    end
  end

endmodule

// File: rtl/vga_pattern_sched.sv
// Frame-synchronous test-pattern scheduler.
//   clk, rst        : pixel clock, asynchronous active-low reset
//   vsync           : vertical sync from the sync generator
//   mode_auto       : 1 auto-advance every dwell frames, 0 manual step
//   step_req        : manual advance request (collapses to one per frame)
//   cfg_valid/ready : host handshake for cfg_pattern / cfg_dwell
//   pattern_sel     : current pattern index
//   pattern_update  : pulses in the cycle pattern_sel changes
//   frame_start     : one pulse per frame boundary
// All pattern/dwell changes are registered on the same edge that raises
// frame_start, so they land inside vertical blanking.
module vga_pattern_sched #(
  parameter int unsigned NUM_PATTERNS     = 8,
  parameter int unsigned PAT_BITS         = 3,
  parameter int unsigned DWELL_BITS       = 8,
  parameter int unsigned DEFAULT_DWELL    = 60,
  parameter bit          VSYNC_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vsync,
  input  logic                  mode_auto,
  input  logic                  step_req,
  input  logic                  cfg_valid,
  input  logic [PAT_BITS-1:0]   cfg_pattern,
  input  logic [DWELL_BITS-1:0] cfg_dwell,
  output logic                  cfg_ready,
  output logic [PAT_BITS-1:0]   pattern_sel,
  output logic                  pattern_update,
  output logic                  frame_start
);
  import vga_pkg::*;

  localparam logic [DWELL_BITS-1:0] DWELL_RST = DWELL_BITS'(DEFAULT_DWELL);
  localparam logic [PAT_BITS-1:0]   PAT_MAX   = PAT_BITS'(NUM_PATTERNS - 1);
  localparam logic [PAT_BITS:0]     PAT_LIMIT = (PAT_BITS + 1)'(NUM_PATTERNS);

  sched_state_t          state, state_d, mode_d;
  logic [PAT_BITS-1:0]   sel_d, adv_pat, cfg_src, cfg_pat_q, cpat_d, new_pat;
  logic [DWELL_BITS-1:0] dwell, dwell_d, frame_cnt, cnt_d, dwell_m1;
  logic [DWELL_BITS-1:0] cfg_dwell_q, cdwell_d;
  logic                  step_pend, step_d, cfg_pend, pend_d, upd_d, ready_d;
  logic                  accept, frame_edge;

  vga_frame_edge #(
    .ACTIVE_LOW (VSYNC_ACTIVE_LOW)
  ) u_frame_edge (
    .clk         (clk),
    .rst         (rst),
    .sync_in     (vsync),
    .frame_edge  (frame_edge),
    .frame_start (frame_start)
  );

  assign accept   = cfg_valid & cfg_ready;
  assign adv_pat  = (pattern_sel == PAT_MAX) ? '0 : pattern_sel + PAT_BITS'(1);
  assign dwell_m1 = (dwell == '0) ? '0 : dwell - DWELL_BITS'(1);
  // A transfer accepted on the boundary edge itself is applied directly.
  assign cfg_src  = accept ? cfg_pattern : cfg_pat_q;
  assign new_pat  = ({1'b0, cfg_src} >= PAT_LIMIT) ? '0 : cfg_src;

  always_comb begin
    state_d  = state;
    sel_d    = pattern_sel;
    upd_d    = 1'b0;
    cnt_d    = frame_cnt;
    dwell_d  = dwell;
    step_d   = step_pend | step_req;
    pend_d   = cfg_pend;
    cpat_d   = cfg_pat_q;
    cdwell_d = cfg_dwell_q;
    mode_d   = mode_auto ? ST_AUTO : ST_MANUAL;
    if (frame_edge) begin
      if (cfg_pend || accept) begin
        sel_d   = new_pat;
        upd_d   = (new_pat != pattern_sel);
        dwell_d = accept ? cfg_dwell : cfg_dwell_q;
        cnt_d   = '0;
        step_d  = 1'b0;
        pend_d  = 1'b0;
      end else if (state == ST_IDLE) begin
        step_d = 1'b0;
      end else if (state != mode_d) begin
        cnt_d  = '0;
        step_d = 1'b0;
      end else if (state == ST_AUTO) begin
        if (frame_cnt >= dwell_m1) begin
          sel_d = adv_pat;
          cnt_d = '0;
          upd_d = 1'b1;
        end else begin
          cnt_d = frame_cnt + DWELL_BITS'(1);
        end
      end else begin
        if (step_d) begin
          sel_d = adv_pat;
          upd_d = 1'b1;
        end
        step_d = 1'b0;
      end
      state_d = mode_d;
    end else if (accept) begin
      pend_d   = 1'b1;
      cpat_d   = cfg_pattern;
      cdwell_d = cfg_dwell;
    end
    // Ready stays low through the frame_start cycle and returns one cycle later.
    if (accept) begin
      ready_d = 1'b0;
    end else if (frame_start && !cfg_pend) begin
      ready_d = 1'b1;
    end else begin
      ready_d = cfg_ready;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      pattern_sel    <= '0;
      pattern_update <= 1'b0;
      frame_cnt      <= '0;
      dwell          <= DWELL_RST;
      step_pend      <= 1'b0;
      cfg_pend       <= 1'b0;
      cfg_pat_q      <= '0;
      cfg_dwell_q    <= '0;
      cfg_ready      <= 1'b1;
    end else begin
      state          <= state_d;
      pattern_sel    <= sel_d;
      pattern_update <= upd_d;
      frame_cnt      <= cnt_d;
      dwell          <= dwell_d;
      step_pend      <= step_d;
      cfg_pend       <= pend_d;
      cfg_pat_q      <= cpat_d;
      cfg_dwell_q    <= cdwell_d;
      cfg_ready      <= ready_d;
    end
  end

endmodule
